// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered ALU operand-select stage with valid/ready flow control
// Optional one-entry skid buffer enabled by defining ALU_OPSTAGE_SKID_EN.
module alu_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 3,
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] srcA_bus,
    input  logic [NUM_SRC*DATA_W-1:0] srcB_bus,
    input  logic [SEL_W-1:0]          selA,
    input  logic [SEL_W-1:0]          selB,
    input  logic [TAG_W-1:0]          tag_in,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         aluValA,
    output logic [DATA_W-1:0]         aluValB,
    output logic [TAG_W-1:0]          tag_out,
    output logic                      sel_err
);

    localparam int ENT_W = TAG_W + 2 * DATA_W;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              hit_a;
    logic              hit_b;
    logic [ENT_W-1:0]  in_ent;
    logic              accept;
    logic              load_out;

    logic              out_valid_q, out_valid_d;
    logic [ENT_W-1:0]  out_ent_q, out_ent_d;
    logic              sel_err_q, sel_err_d;

    // An out-of-range select matches no source, so the operand stays zero.
    always_comb begin
        op_a  = '0;
        op_b  = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (selA == SEL_W'(i)) begin
                op_a  = srcA_bus[i*DATA_W +: DATA_W];
                hit_a = 1'b1;
            end
            if (selB == SEL_W'(i)) begin
                op_b  = srcB_bus[i*DATA_W +: DATA_W];
                hit_b = 1'b1;
            end
        end
    end

    assign in_ent    = {tag_in, op_b, op_a};
    assign accept    = in_valid & in_ready;
    assign load_out  = !out_valid_q | out_ready;
    assign sel_err_d = sel_err_q | (accept & ~(hit_a & hit_b));

`ifdef ALU_OPSTAGE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [ENT_W-1:0] skid_ent_q, skid_ent_d;

    assign in_ready = !skid_valid_q;

    // A parked entry always drains to the output before new input is taken.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ent_d    = out_ent_q;
        skid_valid_d = skid_valid_q;
        skid_ent_d   = skid_ent_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_ent_d    = skid_ent_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_ent_d = in_ent;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ent_d   = in_ent;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_ent_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ent_q   <= skid_ent_d;
        end
    end
`else
    assign in_ready = load_out;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ent_d   = out_ent_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load_out) begin
            out_valid_d = accept;
            if (accept) begin
                out_ent_d = in_ent;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ent_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ent_q   <= out_ent_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign aluValA   = out_ent_q[DATA_W-1:0];
    assign aluValB   = out_ent_q[2*DATA_W-1:DATA_W];
    assign tag_out   = out_ent_q[ENT_W-1:2*DATA_W];
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage (three configurations)
module tb_alu_operand_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, flush;
    logic [1:0]  selA, selB;
    logic [2:0]  tag_in;
    logic [31:0] srcA [4];
    logic [31:0] srcB [4];

    logic [127:0] busA0, busB0;
    logic [95:0]  busA1, busB1;
    logic [31:0]  busA2, busB2;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        err0, err1, err2;
    logic [31:0] a0, b0, a1, b1;
    logic [15:0] a2, b2;
    logic [2:0]  tag0, tag1;
    logic        tag2;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic rdy_seen;

    always #5 clk = ~clk;

    assign busA0 = {srcA[3], srcA[2], srcA[1], srcA[0]};
    assign busB0 = {srcB[3], srcB[2], srcB[1], srcB[0]};
    assign busA1 = {srcA[2], srcA[1], srcA[0]};
    assign busB1 = {srcB[2], srcB[1], srcB[0]};
    assign busA2 = {srcA[1][15:0], srcA[0][15:0]};
    assign busB2 = {srcB[1][15:0], srcB[0][15:0]};

    alu_operand_stage #(.DATA_W(32), .NUM_SRC(4), .TAG_W(3)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .srcA_bus(busA0), .srcB_bus(busB0), .selA(selA), .selB(selB), .tag_in(tag_in),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .aluValA(a0), .aluValB(b0), .tag_out(tag0), .sel_err(err0));

    alu_operand_stage #(.DATA_W(32), .NUM_SRC(3), .TAG_W(3)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .srcA_bus(busA1), .srcB_bus(busB1), .selA(selA), .selB(selB), .tag_in(tag_in),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .aluValA(a1), .aluValB(b1), .tag_out(tag1), .sel_err(err1));

    alu_operand_stage #(.DATA_W(16), .NUM_SRC(2), .TAG_W(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .srcA_bus(busA2), .srcB_bus(busB2), .selA(selA[0]), .selB(selB[0]), .tag_in(tag_in[0]),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .aluValA(a2), .aluValB(b2), .tag_out(tag2), .sel_err(err2));

    function automatic exp_t model(input int nsrc, input int dw, input int tw,
                                   input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] tg);
        exp_t        e;
        int          ia, ib;
        logic [31:0] dmask;
        ia    = (nsrc <= 2) ? int'(sa[0]) : int'(sa);
        ib    = (nsrc <= 2) ? int'(sb[0]) : int'(sb);
        dmask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
        e.a   = (ia < nsrc) ? (srcA[ia] & dmask) : 32'h0;
        e.b   = (ib < nsrc) ? (srcB[ib] & dmask) : 32'h0;
        e.tag = tg & 3'((1 << tw) - 1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic beat_cmp(input string nm, input exp_t act, input exp_t expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s_beat: got a=%h b=%h tag=%0d expected a=%h b=%h tag=%0d",
                     nm, act.a, act.b, act.tag, expv.a, expv.b, expv.tag);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] a, input logic [2:0] t);
        n_cmp++;
        n_fail++;
        $display("FAIL %s_unexpected: got a=%h tag=%0d expected no beat", nm, a, t);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid0 && out_ready) begin
            if (q0.size() == 0) unexpected("dut0", a0, tag0);
            else begin
                e0 = q0.pop_front();
                beat_cmp("dut0", exp_t'{a0, b0, tag0}, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid1 && out_ready) begin
            if (q1.size() == 0) unexpected("dut1", a1, tag1);
            else begin
                e1 = q1.pop_front();
                beat_cmp("dut1", exp_t'{a1, b1, tag1}, e1);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid2 && out_ready) begin
            if (q2.size() == 0) unexpected("dut2", {16'h0, a2}, {2'b0, tag2});
            else begin
                e2 = q2.pop_front();
                beat_cmp("dut2", exp_t'{{16'h0, a2}, {16'h0, b2}, {2'b0, tag2}}, e2);
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic ordy, input logic fl,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] tg);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        selA      = sa;
        selB      = sb;
        tag_in    = tg;
        @(negedge clk);
        rdy_seen = in_ready0;
        if (v && !fl) begin
            if (in_ready0) q0.push_back(model(4, 32, 3, sa, sb, tg));
            if (in_ready1) q1.push_back(model(3, 32, 3, sa, sb, tg));
            if (in_ready2) q2.push_back(model(2, 16, 1, sa, sb, tg));
        end
        if (fl) begin
            #1;
            q0.delete();
            q1.delete();
            q2.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] snap_a, snap_b;
    logic [2:0]  snap_t;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        selA = 2'd0; selB = 2'd0; tag_in = 3'd0;
        srcA[0] = 32'h1111_8001; srcA[1] = 32'h2222_8002;
        srcA[2] = 32'h3333_0003; srcA[3] = 32'h4444_F004;
        srcB[0] = 32'd1; srcB[1] = 32'd2; srcB[2] = 32'd3; srcB[3] = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", {31'b0, out_valid0}, 32'd0);
        chk("rst_a0", a0, 32'd0);
        chk("rst_b0", b0, 32'd0);
        chk("rst_tag0", {29'b0, tag0}, 32'd0);
        chk("rst_err1", {31'b0, err1}, 32'd0);
        reset = 1'b0;

        // select map and bad select
        step(1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 3'd5);
        chk("sel_a0", a0, 32'h2222_8002);
        chk("sel_b0", b0, 32'd1);
        chk("sel_tag0", {29'b0, tag0}, 32'd5);
        chk("sel_a2", {16'h0, a2}, 32'h0000_8002);
        chk("sel_tag2", {31'b0, tag2}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 3'd2);
        chk("sel_b3", b0, 32'd4);
        chk("bad_b1", b1, 32'd0);
        chk("bad_err1", {31'b0, err1}, 32'd1);
        chk("ok_err0", {31'b0, err0}, 32'd0);
        chk("ok_err2", {31'b0, err2}, 32'd0);
        chk("narrow_b2", {16'h0, b2}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'(i), 2'(3 - i), 3'(i + 1));
            chk("thru_valid0", {31'b0, out_valid0}, 32'd1);
            chk("thru_tag0", {29'b0, tag0}, 32'(i + 1));
        end
        step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        chk("drain_valid0", {31'b0, out_valid0}, 32'd0);
        chk("sticky_err1", {31'b0, err1}, 32'd1);

        // stall
        srcA[2] = 32'hCAFE_7777;
        step(1'b1, 1'b1, 1'b0, 2'd2, 2'd1, 3'd3);
        snap_a = a0; snap_b = b0; snap_t = tag0;
        chk("stall_start_a0", a0, 32'hCAFE_7777);
        for (int k = 0; k < 3; k++) begin
            srcA[2] = srcA[2] + 32'h0101_0101;
            step(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 3'(4 + k));
            chk("stall_valid0", {31'b0, out_valid0}, 32'd1);
            chk("stall_a0", a0, snap_a);
            chk("stall_b0", b0, snap_b);
            chk("stall_tag0", {29'b0, tag0}, {29'b0, snap_t});
`ifdef ALU_OPSTAGE_SKID_EN
            chk("stall_rdy0", {31'b0, rdy_seen}, (k == 0) ? 32'd1 : 32'd0);
`else
            chk("stall_rdy0", {31'b0, rdy_seen}, 32'd0);
`endif
        end
        repeat (3) step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        chk("stall_q0_empty", 32'(q0.size()), 32'd0);
        chk("stall_q2_empty", 32'(q2.size()), 32'd0);

        // flush colliding with accept and consume
        step(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 3'd6);
        srcA[0] = 32'hBAD0_BAD0;
        step(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 3'd7);
        chk("flush_valid0", {31'b0, out_valid0}, 32'd0);
        chk("flush_valid1", {31'b0, out_valid1}, 32'd0);
        chk("flush_valid2", {31'b0, out_valid2}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        chk("flush_quiet0", {31'b0, out_valid0}, 32'd0);

        // flush while stalled (and skid possibly occupied)
        step(1'b1, 1'b1, 1'b0, 2'd3, 2'd2, 3'd1);
        step(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 3'd2);
        step(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0);
        chk("flush_stall_valid0", {31'b0, out_valid0}, 32'd0);
        chk("flush_stall_rdy0", {31'b0, in_ready0}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 3'd3);
        chk("post_flush_tag0", {29'b0, tag0}, 32'd3);
        step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        chk("post_flush_idle0", {31'b0, out_valid0}, 32'd0);

        // reset mid-stream
        srcB[1] = 32'h0000_1234;
        step(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 3'd4);
        step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0);
        chk("pre_rst_b0", b0, 32'h0000_1234);
        chk("pre_rst_valid0", {31'b0, out_valid0}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid0", {31'b0, out_valid0}, 32'd0);
        chk("mid_rst_a0", a0, 32'd0);
        chk("mid_rst_b0", b0, 32'd0);
        chk("mid_rst_tag0", {29'b0, tag0}, 32'd0);
        chk("mid_rst_err1", {31'b0, err1}, 32'd0);
        q0.delete(); q1.delete(); q2.delete();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 3'd1);
        chk("after_rst_valid0", {31'b0, out_valid0}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        chk("end_q0", 32'(q0.size()), 32'd0);
        chk("end_q1", 32'(q1.size()), 32'd0);
        chk("end_q2", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
